// File: rtl/bram_pass_arbiter.sv
// Whole-pass arbiter sharing one bram_blocks_rw buffer between NUM_REQ requesters.
// Optional BRAM_ARB_FIXED_PRIORITY_EN selects fixed priority instead of round-robin.
module bram_pass_arbiter #(
   parameter int REGISTER_SIZE = 32,
   parameter int NUM_BLOCKS    = 128,
   parameter int NUM_REQ       = 2
) (
   input  logic                             clk_in,
   input  logic                             rst_in,
   input  logic [NUM_REQ-1:0]               req_in,
   input  logic [NUM_REQ-1:0]               req_write_in,
   output logic [NUM_REQ-1:0]               grant_out,
   output logic                             busy_out,
   input  logic [NUM_REQ-1:0]               wr_valid_in,
   input  logic [NUM_REQ*REGISTER_SIZE-1:0] wr_data_in,
   output logic [REGISTER_SIZE-1:0]         rd_data_out,
   output logic [NUM_REQ-1:0]               rd_valid_out,
   output logic [NUM_REQ-1:0]               pass_done_out,
   output logic                             buf_read_next_out,
   input  logic [REGISTER_SIZE-1:0]         buf_read_data_in,
   input  logic                             buf_read_valid_in,
   output logic                             buf_write_next_out,
   output logic [REGISTER_SIZE-1:0]         buf_write_data_out
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(NUM_BLOCKS + 1);
   localparam logic [CW-1:0] LAST = CW'(NUM_BLOCKS - 1);
   localparam logic [CW-1:0] FULL = CW'(NUM_BLOCKS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ_ISSUE,
      S_READ_DRAIN,
      S_WRITE,
      S_DONE
   } state_t;

   state_t                   r_state;
   logic [IW-1:0]            r_owner;
   logic [CW-1:0]            r_iss_cnt;
   logic [CW-1:0]            r_ret_cnt;
   logic [CW-1:0]            r_wr_cnt;
   logic [NUM_REQ-1:0]       r_grant;
   logic [NUM_REQ-1:0]       r_rd_valid;
   logic [NUM_REQ-1:0]       r_done;
   logic [REGISTER_SIZE-1:0] r_rd_data;

   logic [IW-1:0]            w_pick;
   logic [IW-1:0]            w_idx;
   logic                     w_any;
   logic                     w_wr_acc;
   logic                     w_rd_state;

`ifdef BRAM_ARB_FIXED_PRIORITY_EN
   always_comb begin
      w_pick = '0;
      w_idx  = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         w_idx = IW'(i);
         if (req_in[w_idx]) w_pick = w_idx;
      end
   end
`else
   logic [IW-1:0] r_last;
   logic          w_found;

   // Scan starts just after the previous owner so every requester gets a turn.
   always_comb begin
      w_pick  = '0;
      w_idx   = '0;
      w_found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_idx = IW'((int'(r_last) + k) % NUM_REQ);
         if (!w_found && req_in[w_idx]) begin
            w_pick  = w_idx;
            w_found = 1'b1;
         end
      end
   end
`endif

   assign w_any      = |req_in;
   assign w_wr_acc   = (r_state == S_WRITE) && wr_valid_in[r_owner];
   assign w_rd_state = (r_state == S_READ_ISSUE) || (r_state == S_READ_DRAIN);

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state    <= S_IDLE;
         r_owner    <= '0;
         r_iss_cnt  <= '0;
         r_ret_cnt  <= '0;
         r_wr_cnt   <= '0;
         r_grant    <= '0;
         r_rd_valid <= '0;
         r_done     <= '0;
         r_rd_data  <= '0;
`ifndef BRAM_ARB_FIXED_PRIORITY_EN
         r_last     <= IW'(NUM_REQ - 1);
`endif
      end else begin
         r_done     <= '0;
         r_rd_valid <= '0;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_owner   <= w_pick;
                  r_grant   <= NUM_REQ'(1) << w_pick;
                  r_iss_cnt <= '0;
                  r_ret_cnt <= '0;
                  r_wr_cnt  <= '0;
`ifndef BRAM_ARB_FIXED_PRIORITY_EN
                  r_last    <= w_pick;
`endif
                  r_state   <= req_write_in[w_pick] ? S_WRITE : S_READ_ISSUE;
               end
            end
            S_READ_ISSUE: begin
               r_iss_cnt <= r_iss_cnt + 1'b1;
               if (r_iss_cnt == LAST) r_state <= S_READ_DRAIN;
            end
            S_READ_DRAIN: begin
               if (r_ret_cnt == FULL) begin
                  r_state <= S_DONE;
                  r_done  <= r_grant;
               end
            end
            S_WRITE: begin
               if (w_wr_acc) begin
                  r_wr_cnt <= r_wr_cnt + 1'b1;
                  if (r_wr_cnt == LAST) begin
                     r_state <= S_DONE;
                     r_done  <= r_grant;
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_grant <= '0;
            end
            default: r_state <= S_IDLE;
         endcase
         // Returns are only trusted while a read pass owns the buffer.
         if (w_rd_state && buf_read_valid_in && (r_ret_cnt != FULL)) begin
            r_rd_data  <= buf_read_data_in;
            r_rd_valid <= r_grant;
            r_ret_cnt  <= r_ret_cnt + 1'b1;
         end
      end
   end

   assign grant_out          = r_grant;
   assign busy_out           = (r_state != S_IDLE);
   assign rd_data_out        = r_rd_data;
   assign rd_valid_out       = r_rd_valid;
   assign pass_done_out      = r_done;
   assign buf_read_next_out  = (r_state == S_READ_ISSUE);
   assign buf_write_next_out = w_wr_acc;
   assign buf_write_data_out = (r_state == S_WRITE) ?
      wr_data_in[int'(r_owner)*REGISTER_SIZE +: REGISTER_SIZE] : '0;

endmodule

// File: tb/tb_bram_pass_arbiter.sv
// Directed bench for bram_pass_arbiter with a 2-cycle-latency buffer model.
// Covers write/read passes, round-robin, bursty writes, reset abort, spurious valids.
module tb_bram_pass_arbiter;

   logic        clk_in;
   logic        rst_in;
   logic [1:0]  req_in;
   logic [1:0]  req_write_in;
   logic [1:0]  grant_out;
   logic        busy_out;
   logic [1:0]  wr_valid_in;
   logic [63:0] wr_data_in;
   logic [31:0] rd_data_out;
   logic [1:0]  rd_valid_out;
   logic [1:0]  pass_done_out;
   logic        buf_read_next_out;
   logic [31:0] buf_read_data_in;
   logic        buf_read_valid_in;
   logic        buf_write_next_out;
   logic [31:0] buf_write_data_out;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   bram_pass_arbiter #(
      .REGISTER_SIZE(32),
      .NUM_BLOCKS(128),
      .NUM_REQ(2)
   ) dut (
      .clk_in(clk_in),
      .rst_in(rst_in),
      .req_in(req_in),
      .req_write_in(req_write_in),
      .grant_out(grant_out),
      .busy_out(busy_out),
      .wr_valid_in(wr_valid_in),
      .wr_data_in(wr_data_in),
      .rd_data_out(rd_data_out),
      .rd_valid_out(rd_valid_out),
      .pass_done_out(pass_done_out),
      .buf_read_next_out(buf_read_next_out),
      .buf_read_data_in(buf_read_data_in),
      .buf_read_valid_in(buf_read_valid_in),
      .buf_write_next_out(buf_write_next_out),
      .buf_write_data_out(buf_write_data_out)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc++;

   // Buffer model: wrapping counters, two-stage read pipe, shares rst_in.
   logic [31:0] mem [0:127];
   logic [6:0]  m_raddr, m_waddr;
   logic        m_p1v, m_v;
   logic [31:0] m_p1d, m_d;
   logic        spur;
   logic [31:0] spur_d;

   assign buf_read_valid_in = m_v | spur;
   assign buf_read_data_in  = spur ? spur_d : m_d;

   always @(posedge clk_in) begin
      if (rst_in) begin
         m_raddr <= '0;
         m_waddr <= '0;
         m_p1v   <= 1'b0;
         m_v     <= 1'b0;
      end else begin
         if (buf_write_next_out) begin
            mem[m_waddr] <= buf_write_data_out;
            m_waddr      <= m_waddr + 1'b1;
         end
         m_p1v <= buf_read_next_out;
         if (buf_read_next_out) begin
            m_p1d   <= mem[m_raddr];
            m_raddr <= m_raddr + 1'b1;
         end
         m_v <= m_p1v;
         m_d <= m_p1d;
      end
   end

   task automatic test_reset();
      rst_in = 1'b1;
      req_in = '0;
      wr_valid_in = '0;
      @(negedge clk_in);
      @(negedge clk_in);
      tests++;
      if ({grant_out, busy_out, rd_valid_out, pass_done_out,
           buf_read_next_out, buf_write_next_out} !== 8'h00 ||
          rd_data_out !== 32'h0 || buf_write_data_out !== 32'h0) begin
         fails++;
         $display("FAIL reset_outputs grant=%b busy=%b rdv=%b done=%b rd=%h want all 0",
                  grant_out, busy_out, rd_valid_out, pass_done_out, rd_data_out);
      end
      rst_in = 1'b0;
      @(negedge clk_in);
   endtask

   task automatic test_spurious();
      spur   = 1'b1;
      spur_d = 32'hABCD1234;
      @(negedge clk_in);
      spur = 1'b0;
      tests++;
      if (rd_valid_out !== 2'b00 || busy_out !== 1'b0) begin
         fails++;
         $display("FAIL spur_valid0 rdv=%b busy=%b want 00/0", rd_valid_out, busy_out);
      end
      @(negedge clk_in);
      tests++;
      if (rd_valid_out !== 2'b00 || rd_data_out !== 32'h0) begin
         fails++;
         $display("FAIL spur_valid1 rdv=%b rd=%h want 00/0", rd_valid_out, rd_data_out);
      end
   endtask

   task automatic test_write_read();
      int bad = 0;
      int fi = -1, fv = -1, lv = -1, dn = -1, g = -1, nis = 0, nv = 0;
      req_in = 2'b01;
      req_write_in = 2'b01;
      @(negedge clk_in);
      tests++;
      if (grant_out !== 2'b01 || busy_out !== 1'b1) begin
         fails++;
         $display("FAIL wr_grant grant=%b busy=%b want 01/1", grant_out, busy_out);
      end
      req_in = 2'b00;
      for (int k = 0; k < 128; k++) begin
         wr_valid_in = 2'b01;
         wr_data_in  = {32'h0, 32'(k * 3)};
         #1;
         if (buf_write_next_out !== 1'b1 || buf_write_data_out !== 32'(k * 3)) bad++;
         @(negedge clk_in);
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL wr_stream bad=%0d want 0", bad);
      end
      #1;
      tests++;
      if (pass_done_out !== 2'b01 || grant_out !== 2'b01 || buf_write_next_out !== 1'b0) begin
         fails++;
         $display("FAIL wr_done done=%b grant=%b wnext=%b want 01/01/0",
                  pass_done_out, grant_out, buf_write_next_out);
      end
      wr_valid_in = 2'b00;
      @(negedge clk_in);
      tests++;
      if (grant_out !== 2'b00 || busy_out !== 1'b0 || pass_done_out !== 2'b00) begin
         fails++;
         $display("FAIL wr_idle grant=%b busy=%b done=%b want 00/0/00",
                  grant_out, busy_out, pass_done_out);
      end
      bad = 0;
      req_in = 2'b01;
      req_write_in = 2'b00;
      for (int t = 0; t < 400 && dn < 0; t++) begin
         @(negedge clk_in);
         if (grant_out == 2'b01 && g < 0) begin
            g = cyc;
            req_in = 2'b00;
         end
         if (buf_read_next_out) begin
            nis++;
            if (fi < 0) fi = cyc;
         end
         if (rd_valid_out[0]) begin
            if (rd_data_out !== 32'(nv * 3)) bad++;
            if (fv < 0) fv = cyc;
            lv = cyc;
            nv++;
         end
         if (grant_out[1] || rd_valid_out[1]) bad++;
         if (pass_done_out == 2'b01) begin
            dn = cyc;
            if (grant_out !== 2'b01) bad++;
         end
      end
      tests++;
      if (dn < 0 || fi != g || nis != 128 || nv != 128 || bad != 0) begin
         fails++;
         $display("FAIL rd_pass done=%0d issue@%0d grant@%0d issues=%0d valids=%0d bad=%0d want 128/128/0",
                  dn, fi, g, nis, nv, bad);
      end
      tests++;
      if (fv - fi != 3 || lv - fi != 130) begin
         fails++;
         $display("FAIL rd_latency first=%0d last=%0d want 3/130", fv - fi, lv - fi);
      end
      tests++;
      if (dn - lv != 1) begin
         fails++;
         $display("FAIL rd_done_gap got=%0d want 1", dn - lv);
      end
      @(negedge clk_in);
      tests++;
      if (busy_out !== 1'b0 || pass_done_out !== 2'b00) begin
         fails++;
         $display("FAIL rd_idle busy=%b done=%b want 0/00", busy_out, pass_done_out);
      end
   endtask

   task automatic test_bursty_write();
      int bad = 0, acc = 0, c = 0;
      logic v1;
      req_in = 2'b10;
      req_write_in = 2'b10;
      @(negedge clk_in);
      tests++;
      if (grant_out !== 2'b10) begin
         fails++;
         $display("FAIL bw_grant grant=%b want 10", grant_out);
      end
      req_in = 2'b00;
      while (acc < 128 && c < 1000) begin
         v1 = (c % 3 == 0);
         wr_valid_in = {v1, c[0]};
         wr_data_in  = {32'(1000 + acc), 32'hDEAD0000 | 32'(c)};
         #1;
         if (buf_write_next_out !== v1) bad++;
         if (v1 && buf_write_data_out !== 32'(1000 + acc)) bad++;
         if (pass_done_out !== 2'b00) bad++;
         if (v1) acc++;
         c++;
         @(negedge clk_in);
      end
      tests++;
      if (bad != 0 || acc != 128) begin
         fails++;
         $display("FAIL bw_stream bad=%0d accepts=%0d want 0/128", bad, acc);
      end
      tests++;
      if (pass_done_out !== 2'b10 || grant_out !== 2'b10) begin
         fails++;
         $display("FAIL bw_done done=%b grant=%b want 10/10", pass_done_out, grant_out);
      end
      wr_valid_in = 2'b00;
      @(negedge clk_in);
   endtask

   task automatic test_req_drop();
      int bad = 0, nv = 0, dn = -1, gs = 0;
      req_in = 2'b01;
      req_write_in = 2'b00;
      for (int t = 0; t < 400 && dn < 0; t++) begin
         @(negedge clk_in);
         if (gs == 1) req_in = 2'b00;
         if (grant_out == 2'b01 && gs < 2) gs++;
         if (rd_valid_out[0]) begin
            if (rd_data_out !== 32'(1000 + nv)) bad++;
            nv++;
         end
         if (pass_done_out == 2'b01) dn = cyc;
      end
      tests++;
      if (dn < 0 || nv != 128 || bad != 0) begin
         fails++;
         $display("FAIL drop_pass done=%0d valids=%0d bad=%0d want 128/0", dn, nv, bad);
      end
      @(negedge clk_in);
   endtask

   task automatic test_round_robin();
      int gown[4], gst[4], gdn[4];
      int ng = 0, nd = 0, twohot = 0, bad = 0, e;
      logic [1:0] prevg = 2'b00;
      rst_in = 1'b1;
      @(negedge clk_in);
      rst_in = 1'b0;
      req_in = 2'b11;
      req_write_in = 2'b00;
      for (int t = 0; t < 1000 && nd < 4; t++) begin
         @(negedge clk_in);
         if (grant_out == 2'b11) twohot++;
         if ((rd_valid_out & ~grant_out) != 2'b00) bad++;
         if (grant_out != 2'b00 && prevg == 2'b00 && ng < 4) begin
            gown[ng] = (grant_out == 2'b10) ? 1 : 0;
            gst[ng]  = cyc;
            ng++;
         end
         if (pass_done_out != 2'b00) begin
            gdn[nd] = cyc;
            nd++;
         end
         prevg = grant_out;
      end
      req_in = 2'b00;
      tests++;
      if (nd != 4 || ng != 4) begin
         fails++;
         $display("FAIL rr_timeout grants=%0d dones=%0d want 4/4", ng, nd);
      end else begin
         for (int i = 0; i < 4; i++) begin
`ifdef BRAM_ARB_FIXED_PRIORITY_EN
            e = 0;
`else
            e = i % 2;
`endif
            tests++;
            if (gown[i] != e) begin
               fails++;
               $display("FAIL rr_owner%0d got=%0d want %0d", i, gown[i], e);
            end
         end
         for (int i = 0; i < 3; i++) begin
            tests++;
            if (gst[i+1] - gdn[i] != 2) begin
               fails++;
               $display("FAIL rr_gap%0d got=%0d want 2", i, gst[i+1] - gdn[i]);
            end
         end
      end
      tests++;
      if (twohot != 0 || bad != 0) begin
         fails++;
         $display("FAIL rr_onehot twohot=%0d stray_valid=%0d want 0/0", twohot, bad);
      end
      @(negedge clk_in);
      @(negedge clk_in);
   endtask

   task automatic test_reset_mid_read();
      int nv = 0, dn = -1;
      logic [31:0] first = 32'h0;
      req_in = 2'b01;
      req_write_in = 2'b00;
      for (int t = 0; t < 200 && nv < 50; t++) begin
         @(negedge clk_in);
         req_in = 2'b00;
         if (rd_valid_out[0]) nv++;
      end
      rst_in = 1'b1;
      @(negedge clk_in);
      tests++;
      if (nv != 50 || grant_out !== 2'b00 || busy_out !== 1'b0 || rd_valid_out !== 2'b00 ||
          pass_done_out !== 2'b00 || buf_read_next_out !== 1'b0 ||
          buf_write_next_out !== 1'b0 || rd_data_out !== 32'h0) begin
         fails++;
         $display("FAIL rst_mid seen=%0d grant=%b busy=%b rdv=%b rnext=%b rd=%h want 50 then all 0",
                  nv, grant_out, busy_out, rd_valid_out, buf_read_next_out, rd_data_out);
      end
      rst_in = 1'b0;
      req_in = 2'b01;
      nv = 0;
      for (int t = 0; t < 400 && dn < 0; t++) begin
         @(negedge clk_in);
         if (grant_out == 2'b01) req_in = 2'b00;
         if (rd_valid_out[0]) begin
            if (nv == 0) first = rd_data_out;
            nv++;
         end
         if (pass_done_out == 2'b01) dn = cyc;
      end
      tests++;
      if (first !== 32'd1000 || nv != 128 || dn < 0) begin
         fails++;
         $display("FAIL rst_realign first=%h valids=%0d done=%0d want 000003e8/128", first, nv, dn);
      end
      @(negedge clk_in);
   endtask

   initial begin
      rst_in       = 1'b1;
      req_in       = '0;
      req_write_in = '0;
      wr_valid_in  = '0;
      wr_data_in   = '0;
      spur         = 1'b0;
      spur_d       = '0;
      test_reset();
      test_spurious();
      test_write_read();
      test_bursty_write();
      test_req_drop();
      test_round_robin();
      test_reset_mid_read();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/bram_pass_arbiter.md
Name: bram_pass_arbiter

Overview:
- Sequences and shares one bram_blocks_rw block buffer between NUM_REQ requesters (e.g. modexp operand loader, result unloader).
- Grants whole-buffer passes: a read pass streams all NUM_BLOCKS words out; a write pass accepts exactly NUM_BLOCKS words in.
- Full passes only, so the buffer's wrapping read/write address counters stay aligned to block 0.
- Sits between the requesters and the buffer's read_next/write_next strobes.

Parameters:
REGISTER_SIZE, 32, width of one block word
NUM_BLOCKS, 128, blocks per pass (must match buffer)
NUM_REQ, 2, number of requesters (>=2)

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset; also drives the buffer's reset
req_in  input  NUM_REQ  level request per requester
req_write_in  input  NUM_REQ  1 = write pass, 0 = read pass; sampled at grant
grant_out  output  NUM_REQ  one-hot owner of current pass
busy_out  output  1  high whenever state != IDLE
wr_valid_in  input  NUM_REQ  per-requester write strobe
wr_data_in  input  NUM_REQ*REGISTER_SIZE  packed write words, requester i at [i*REGISTER_SIZE +: REGISTER_SIZE]
rd_data_out  output  REGISTER_SIZE  registered read word, broadcast
rd_valid_out  output  NUM_REQ  one-hot valid to owner
pass_done_out  output  NUM_REQ  one-cycle pulse to owner at pass end
buf_read_next_out  output  1  to buffer read_next_block_valid_in
buf_read_data_in  input  REGISTER_SIZE  from buffer read_block_out
buf_read_valid_in  input  1  from buffer read_block_pipe2_valid_out
buf_write_next_out  output  1  to buffer write_next_block_valid_in
buf_write_data_out  output  REGISTER_SIZE  to buffer write_block_in

Behaviour:
- Interface: one clock, clk_in. Reset rst_in is synchronous and active-high.
- Reset:
  - State IDLE; all outputs 0; issue/return/write counters 0.
  - Round-robin last-grant pointer = NUM_REQ-1, so requester 0 wins first.
  - Reset mid-pass aborts immediately. The buffer shares rst_in, so its counters realign.
- States: IDLE, READ_ISSUE, READ_DRAIN, WRITE, DONE.
- IDLE:
  - If any req_in bit is set, pick the first set bit after the last-grant pointer (wrapping).
  - Latch the owner and req_write_in[owner]; update the pointer.
  - Next cycle: grant_out set, go to READ_ISSUE or WRITE.
- Grant/request hold:
  - grant_out is held through the DONE cycle inclusive.
  - req_in changes during a pass are ignored.
- READ_ISSUE:
  - buf_read_next_out = 1 every cycle for exactly NUM_BLOCKS cycles (no throttling), then READ_DRAIN.
  - Issue cycles are N+1..N+NUM_BLOCKS when arbitration happens in cycle N.
- Read return path:
  - Each buf_read_valid_in in READ_ISSUE/READ_DRAIN registers buf_read_data_in into rd_data_out.
  - rd_valid_out[owner] pulses 1 cycle later, so first valid is 3 cycles after first issue.
  - Return counter increments per valid.
- READ_DRAIN: the cycle after the NUM_BLOCKS-th rd_valid_out, go to DONE.
- WRITE:
  - buf_write_next_out = wr_valid_in[owner]; buf_write_data_out = owner's word (combinational mux).
  - Non-owner strobes are ignored. No timeout: the owner may idle arbitrarily.
  - After NUM_BLOCKS accepts, next cycle is DONE. Strobes arriving in DONE are ignored.
- DONE: pass_done_out[owner] = 1 for one cycle, then IDLE. Earliest next grant is 2 cycles after DONE.
- Unsolicited buf_read_valid_in outside read states is ignored. rd_data_out holds its last value.
- Counters are $clog2(NUM_BLOCKS+1) bits wide and compare to NUM_BLOCKS; no wrap inside a pass.
- Default timeline, read pass arbitrated in cycle N:
  - grant N+1; issue N+1..N+128; rd_valid N+4..N+131.
  - DONE N+132; IDLE N+133; next grant N+134.

Optional Feature:
- Macro BRAM_ARB_FIXED_PRIORITY_EN.
- Defined: fixed priority, lowest index wins; the last-grant pointer is unused.
- Undefined: round-robin as above.

Test Plan:
- Write then read, single requester: req0 write pass, words 0..127 = k*3. Then req0 read pass: rd_valid_out[0] 128 pulses with k*3 in order; first pulse 3 cycles after first buf_read_next_out; pass_done_out[0] one cycle after the last.
- Round-robin: req_in=2'b11 held constantly, both read. Grants alternate 0,1,0,1. grant_out is never two-hot. Grant gap between passes is 2 cycles. With BRAM_ARB_FIXED_PRIORITY_EN defined, requester 0 is granted every time.
- Bursty write: owner 1 asserts wr_valid_in every third cycle while requester 0 toggles wr_valid_in[0]. buf_write_next_out follows only wr_valid_in[1]. DONE follows the 128th accept by exactly 1 cycle.
- Reset mid-read at block 50: next cycle all outputs 0, state IDLE. A new read pass returns word 0 first.
- Request dropped after grant: req_in[0] falls 1 cycle after grant. The pass still completes all 128 words and pass_done_out[0] pulses.
- Spurious buf_read_valid_in pulse in IDLE: no rd_valid_out, rd_data_out unchanged.
